// File: rtl/pwm_capture.sv
// PWM high-time and period capture. pwm_in is synchronized, edge-detected and
// measured between consecutive rising edges; a stalled input is flagged as stuck.
module pwm_capture #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             valid,
    output logic             stuck,
    output logic             level
);

    localparam logic [CNT_W-1:0] MaxCnt = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    logic             s1_q, s2_q, s3_q;
    logic             rise, fall;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_hi_q, cnt_hi_d;
    logic [CNT_W-1:0] cnt_per_q, cnt_per_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic             valid_q, valid_d;
    logic             stuck_q, stuck_d;

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            state_q      <= StIdle;
            cnt_hi_q     <= '0;
            cnt_per_q    <= '0;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            valid_q      <= 1'b0;
            stuck_q      <= 1'b0;
        end else begin
            s1_q         <= pwm_in;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            state_q      <= state_d;
            cnt_hi_q     <= cnt_hi_d;
            cnt_per_q    <= cnt_per_d;
            high_cnt_q   <= high_cnt_d;
            period_cnt_q <= period_cnt_d;
            valid_q      <= valid_d;
            stuck_q      <= stuck_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_hi_d     = cnt_hi_q;
        cnt_per_d    = cnt_per_q;
        high_cnt_d   = high_cnt_q;
        period_cnt_d = period_cnt_q;
        valid_d      = 1'b0;
        stuck_d      = stuck_q;

        if (!en) begin
            state_d   = StIdle;
            cnt_hi_d  = '0;
            cnt_per_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_d   = StHigh;
                        cnt_hi_d  = OneCnt;
                        cnt_per_d = OneCnt;
                        stuck_d   = 1'b0;
                    end
                end
                StHigh, StLow: begin
                    if (state_q == StLow && rise) begin
                        // A rise closes the period and wins over saturation.
                        high_cnt_d   = cnt_hi_q;
                        period_cnt_d = cnt_per_q;
                        valid_d      = 1'b1;
                        state_d      = StHigh;
                        cnt_hi_d     = OneCnt;
                        cnt_per_d    = OneCnt;
                    end else if (cnt_per_q == MaxCnt) begin
                        // s2 low here covers both a long low and a fall at MAX.
                        high_cnt_d   = s2_q ? MaxCnt : '0;
                        period_cnt_d = MaxCnt;
                        valid_d      = 1'b1;
                        stuck_d      = 1'b1;
                        state_d      = StIdle;
                        cnt_hi_d     = '0;
                        cnt_per_d    = '0;
                    end else begin
                        cnt_per_d = cnt_per_q + OneCnt;
                        if (state_q == StHigh) begin
                            if (fall) begin
                                state_d = StLow;
                            end else begin
                                cnt_hi_d = cnt_hi_q + OneCnt;
                            end
                        end
                    end
                end
                default: begin
                    state_d   = StIdle;
                    cnt_hi_d  = '0;
                    cnt_per_d = '0;
                end
            endcase
        end
    end

    assign high_cnt   = high_cnt_q;
    assign period_cnt = period_cnt_q;
    assign valid      = valid_q;
    assign stuck      = stuck_q;
    assign level      = s2_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: table of PWM segments plus hand-written
// corner sequences; expected captures are queued at each rise and popped on valid.
module tb_pwm_capture;

    localparam int unsigned CNT_W = 8;
    localparam int MAXV = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             pwm_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             valid;
    logic             stuck;
    logic             level;

    pwm_capture #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pwm_in     (pwm_in),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .valid      (valid),
        .stuck      (stuck),
        .level      (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int per;
        int stk;
    } exp_t;

    typedef struct {
        int h;
        int l;
        int n;
        int exp_hi;
        int exp_per;
    } seg_t;

    exp_t sb[$];
    seg_t segs[4];
    int   total = 0;
    int   bad = 0;
    int   have_prev = 0;
    int   prev_hi = 0;
    int   prev_per = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int hi, input int per, input int stk);
        exp_t e;
        e.hi  = hi;
        e.per = per;
        e.stk = stk;
        sb.push_back(e);
    endtask

    // A rise closes the previous period, if one is being measured.
    task automatic rise_push();
        if (have_prev != 0) push_exp(prev_hi, prev_per, 0);
    endtask

    task automatic drive_period(input int h, input int l, input int eh, input int ep);
        rise_push();
        have_prev = 1;
        prev_hi   = eh;
        prev_per  = ep;
        pwm_in    = 1'b1;
        wait_cyc(h);
        pwm_in    = 1'b0;
        wait_cyc(l);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("valid_unexpected", int'(valid), 0);
            end else begin
                e = sb.pop_front();
                chk("high_cnt", int'(high_cnt), e.hi);
                chk("period_cnt", int'(period_cnt), e.per);
                chk("stuck_at_valid", int'(stuck), e.stk);
            end
        end
    end

    initial begin
        segs[0] = '{h: 3, l: 7, n: 6, exp_hi: 3, exp_per: 10};
        segs[1] = '{h: 7, l: 3, n: 4, exp_hi: 7, exp_per: 10};
        segs[2] = '{h: 1, l: 1, n: 5, exp_hi: 1, exp_per: 2};
        segs[3] = '{h: 2, l: 4, n: 3, exp_hi: 2, exp_per: 6};

        rst    = 1'b1;
        en     = 1'b0;
        pwm_in = 1'b0;
        wait_cyc(1);

        // Reset held while pwm_in toggles.
        for (int i = 0; i < 3; i++) begin
            pwm_in = ~pwm_in;
            wait_cyc(1);
        end
        chk("rst_high_cnt", int'(high_cnt), 0);
        chk("rst_period_cnt", int'(period_cnt), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_stuck", int'(stuck), 0);
        chk("rst_level", int'(level), 0);
        pwm_in = 1'b0;
        rst    = 1'b0;
        en     = 1'b1;
        wait_cyc(3);

        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < segs[s].n; k++) begin
                drive_period(segs[s].h, segs[s].l, segs[s].exp_hi, segs[s].exp_per);
            end
        end

        // Drop en mid-period: outputs hold, measurement abandoned.
        drive_period(3, 2, 3, 5);
        en = 1'b0;
        wait_cyc(5);
        chk("en_hold_high_cnt", int'(high_cnt), 2);
        chk("en_hold_period_cnt", int'(period_cnt), 6);
        chk("en_hold_stuck", int'(stuck), 0);
        en        = 1'b1;
        have_prev = 0;
        wait_cyc(2);
        for (int k = 0; k < 3; k++) drive_period(3, 7, 3, 10);

        // Held high past MAX.
        rise_push();
        push_exp(MAXV, MAXV, 1);
        have_prev = 0;
        pwm_in    = 1'b1;
        wait_cyc(2);
        chk("level_high", int'(level), 1);
        wait_cyc(298);
        chk("sat_hi_stuck", int'(stuck), 1);
        chk("sat_hi_high_cnt", int'(high_cnt), MAXV);
        pwm_in = 1'b0;
        wait_cyc(5);

        // Held low past MAX after a short high.
        pwm_in = 1'b1;
        wait_cyc(3);
        push_exp(0, MAXV, 1);
        pwm_in = 1'b0;
        wait_cyc(300);
        chk("sat_lo_stuck", int'(stuck), 1);
        chk("sat_lo_high_cnt", int'(high_cnt), 0);
        chk("sat_lo_period_cnt", int'(period_cnt), MAXV);

        // Resume: stuck clears on first rise, valid only after the second.
        drive_period(3, 7, 3, 10);
        chk("resume_stuck_clear", int'(stuck), 0);
        for (int k = 0; k < 3; k++) drive_period(3, 7, 3, 10);

        // Reset while in LOW abandons the measurement.
        drive_period(3, 3, 3, 6);
        rst = 1'b1;
        wait_cyc(2);
        chk("midrst_high_cnt", int'(high_cnt), 0);
        chk("midrst_period_cnt", int'(period_cnt), 0);
        chk("midrst_stuck", int'(stuck), 0);
        chk("midrst_valid", int'(valid), 0);
        rst       = 1'b0;
        have_prev = 0;
        wait_cyc(3);
        for (int k = 0; k < 3; k++) drive_period(4, 6, 4, 10);

        wait_cyc(20);
        chk("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
